// File: rtl/bist_sig_analyzer.sv
// Serial-input signature register (Galois SISR) with load/run/check FSM.
// Compacts len response bits from sin into sig and compares against golden.
//
// Ports:
//   clk, rst (async active-low)
//   start  : pulse, begins a run from IDLE or DONE
//   abort  : synchronous return to IDLE, wins over start
//   en/sin : qualified serial response stream
//   poly, seed, golden, len : run setup, captured at start
//   busy, done, pass, sig   : status and current signature
module bist_sig_analyzer #(
    parameter int N  = 8,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          en,
    input  logic          sin,
    input  logic [N-1:0]  poly,
    input  logic [N-1:0]  seed,
    input  logic [N-1:0]  golden,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [N-1:0]  sig
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [LW-1:0] cnt;
    logic [N-1:0]  poly_q;
    logic [N-1:0]  golden_q;
    logic [N-1:0]  sig_nxt;
    logic          fb;

    // One Galois step: the response bit is folded into the feedback,
    // so with sin=0 this matches the pattern generator's sequence.
    always_comb begin
        fb = sig[0] ^ sin;
        sig_nxt = '0;
        sig_nxt[N-1] = fb;
        for (int i = 0; i < N-1; i++) begin
            sig_nxt[i] = (fb & poly_q[i]) ^ sig[i+1];
        end
    end

    assign busy = (state == RUN) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sig      <= '0;
            cnt      <= '0;
            poly_q   <= '0;
            golden_q <= '0;
            pass     <= 1'b0;
        end else if (abort) begin
            // sig is left alone so a partial signature can be inspected
            state <= IDLE;
            pass  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sig      <= seed;
                        poly_q   <= poly;
                        golden_q <= golden;
                        cnt      <= len;
                        pass     <= 1'b0;
                        state    <= (len == '0) ? CHECK : RUN;
                    end
                end
                RUN: begin
                    if (en && (cnt != '0)) begin
                        sig <= sig_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == LW'(1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    pass  <= (sig == golden_q);
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_sig_analyzer.sv
// Self-checking bench for bist_sig_analyzer.
// Scoreboard of expected final signature/pass/latency, popped when done rises.
module tb_bist_sig_analyzer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        en = 1'b0;
    logic        sin = 1'b0;
    logic [7:0]  poly = '0;
    logic [7:0]  seed = '0;
    logic [7:0]  golden = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  sig;

    bist_sig_analyzer #(.N(8), .LW(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .en     (en),
        .sin    (sin),
        .poly   (poly),
        .seed   (seed),
        .golden (golden),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .sig    (sig)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Galois step written as shift-then-xor-mask.
    function automatic logic [7:0] step(input logic [7:0] s,
                                        input logic [7:0] p,
                                        input logic b);
        logic f;
        f = s[0] ^ b;
        return {f, s[7:1]} ^ ({8{f}} & {1'b0, p[6:0]});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_sig", sig, mon_e.sig);
                check("sb_pass", pass, mon_e.pass);
                check("sb_latency", cyc - start_cyc, mon_e.lat);
            end
        end
        done_q = done;
    end

    task automatic do_run(input logic [7:0] p, input logic [7:0] s,
                          input logic [7:0] g, input logic [15:0] l,
                          input logic [63:0] bits, input int gap_at,
                          input int gap_n, input int spur);
        logic [7:0] m;
        exp_t e;
        int gn;
        gn = (gap_at >= 0 && gap_at < int'(l)) ? gap_n : 0;
        m = s;
        for (int k = 0; k < int'(l); k++) m = step(m, p, bits[k]);
        e.sig = m;
        e.pass = (m == g);
        e.lat = int'(l) + gn + 1;
        sb.push_back(e);
        poly = p;
        seed = s;
        golden = g;
        len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_sig", sig, s);
        poly = 8'($urandom);
        seed = 8'($urandom);
        golden = 8'($urandom);
        len = 16'($urandom_range(1, 200));
        m = s;
        for (int k = 0; k < int'(l); k++) begin
            if (k == gap_at) begin
                repeat (gap_n) begin
                    en = 1'b0;
                    sin = 1'b1;
                    tick();
                    check("gap_busy", busy, 1);
                    check("gap_hold", sig, m);
                end
            end
            if (k == spur) start = 1'b1;
            en = 1'b1;
            sin = bits[k];
            tick();
            start = 1'b0;
            m = step(m, p, bits[k]);
            check("bit_sig", sig, m);
        end
        en = 1'b0;
        sin = 1'b0;
        for (int t = 0; t < 8 && !done; t++) tick();
        check("done_seen", done, 1);
    endtask

    logic [7:0] m;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_sig", sig, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // impulse through a plain shift register
        do_run(8'h00, 8'h00, 8'h01, 16'd8, 64'h1, -1, 0, -1);
        check("s2_sig", sig, 8'h01);
        check("s2_pass", pass, 1);

        // single bit into poly 0x1D
        do_run(8'h1D, 8'h00, 8'h9D, 16'd1, 64'h1, -1, 0, -1);
        check("s3_sig", sig, 8'h9D);
        check("s3_pass", pass, 1);
        do_run(8'h1D, 8'h00, 8'h9C, 16'd1, 64'h1, -1, 0, -1);
        check("s3b_pass", pass, 0);
        check("s3b_done", done, 1);

        // en gap of 3 cycles before the fifth bit
        do_run(8'h00, 8'h00, 8'h01, 16'd8, 64'h1, 4, 3, -1);
        check("s4_sig", sig, 8'h01);
        check("s4_pass", pass, 1);

        // zero-length runs
        do_run(8'h1D, 8'h5A, 8'h5A, 16'd0, 64'h0, -1, 0, -1);
        check("s5_sig", sig, 8'h5A);
        check("s5_pass", pass, 1);
        do_run(8'h1D, 8'h5A, 8'h00, 16'd0, 64'h0, -1, 0, -1);
        check("s5b_pass", pass, 0);

        // DONE ignores en/sin
        en = 1'b1;
        sin = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        sin = 1'b0;
        check("hold_sig", sig, 8'h5A);
        check("hold_done", done, 1);
        check("hold_pass", pass, 0);

        // random mixed runs with a spurious start mid-run
        for (int r = 0; r < 4; r++) begin
            do_run(8'($urandom), 8'($urandom), 8'($urandom),
                   16'($urandom_range(1, 40)),
                   {$urandom, $urandom}, 3, r, 2);
        end

        // abort after 3 of 8 bits
        poly = 8'h1D;
        seed = 8'h33;
        golden = 8'h00;
        len = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        m = 8'h33;
        for (int k = 0; k < 3; k++) begin
            en = 1'b1;
            sin = k[0];
            tick();
            m = step(m, 8'h1D, k[0]);
        end
        en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_sig", sig, m);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_sig", sig, m);
        tick();
        check("sa_idle", busy, 0);

        // async reset in the middle of a run
        seed = 8'hC3;
        len = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        sin = 1'b1;
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_sig", sig, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        en = 1'b0;
        sin = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        do_run(8'h1D, 8'h00, 8'h9D, 16'd1, 64'h1, -1, 0, -1);
        check("post_rst_pass", pass, 1);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
